hist2d_core: RTL and testbench



---
 rtl/hist2d_core.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hist2d_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_core.sv
// hist2d_core: 2D histogram of IQ samples on a runtime-configured grid, stored in a 64K x 16 bin RAM.
// Build option HIST2D_SATURATE_EN: bin counters stick at 0xFFFF instead of wrapping to 0x0000.
module hist2d_core (
   input  logic               clk100,
   input  logic               reset,
   input  logic               data_in,
   input  logic signed [31:0] i_val,
   input  logic signed [31:0] q_val,
   input  logic [7:0]         i_bin_num,
   input  logic [7:0]         q_bin_num,
   input  logic [15:0]        i_bin_width,
   input  logic [15:0]        q_bin_width,
   input  logic signed [15:0] i_min,
   input  logic signed [15:0] q_min,
   input  logic [15:0]        num_data_pts,
   input  logic               stream_mode,
   output logic               i_q_found,
   output logic               bin_found,
   output logic [7:0]         i_bin_coord,
   output logic [7:0]         q_bin_coord,
   output logic [15:0]        bin_val
);

   typedef enum logic [3:0] {
      ST_CLEAR, ST_IDLE, ST_OFFSET, ST_DIV, ST_FOUND,
      ST_READ, ST_WAIT, ST_WRITE, ST_DONE, ST_DUMP
   } state_t;

   // Returns {saturate, dividend}; negative or saturated offsets divide as zero.
   function automatic logic [25:0] offset_calc(input logic signed [31:0] v,
                                               input logic signed [15:0] m,
                                               input logic [15:0]        w);
      logic [32:0] off;
      logic        sat;
      off = {v[31], v} - {{17{m[15]}}, m};
      sat = !off[32] && (off[31:0] >= {8'd0, w, 8'd0});
      if (off[32] || sat) begin
         offset_calc = {sat, 25'd0};
      end else begin
         offset_calc = {1'b0, off[24:0]};
      end
   endfunction

   function automatic logic [7:0] clamp_bin(input logic sat, input logic [7:0] quo,
                                            input logic [7:0] nb);
      logic [7:0] q;
      q = sat ? 8'hFF : quo;
      if (q > nb - 8'd1) begin
         clamp_bin = nb - 8'd1;
      end else begin
         clamp_bin = q;
      end
   endfunction

   function automatic logic [15:0] bin_inc(input logic [15:0] cnt);
`ifdef HIST2D_SATURATE_EN
      bin_inc = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;
`else
      bin_inc = cnt + 16'd1;
`endif
   endfunction

   state_t             state, state_nxt;
   logic signed [31:0] i_val_r, q_val_r;
   logic signed [15:0] i_min_r, q_min_r;
   logic [15:0]        i_w_r, q_w_r;
   logic [7:0]         i_nb_r, q_nb_r;
   logic [15:0]        num_pts_r;
   logic               stream_r;
   logic [24:0]        i_rem_r, q_rem_r;
   logic [23:0]        i_dvs_r, q_dvs_r;
   logic [7:0]         i_quo_r, q_quo_r;
   logic               i_sat_r, q_sat_r;
   logic [2:0]         div_cnt;
   logic [15:0]        clr_addr;
   logic [15:0]        pt_cnt;
   logic [7:0]         dump_i, dump_q;
   logic               dump_ph;
   logic [25:0]        i_off_s, q_off_s;
   logic               dump_last_s;
   logic [15:0]        mem [0:65535];
   logic [15:0]        rd_data;
   logic [15:0]        rd_addr;
   logic               mem_we;
   logic [15:0]        mem_waddr;
   logic [15:0]        mem_wdata;

   assign i_off_s     = offset_calc(i_val_r, i_min_r, i_w_r);
   assign q_off_s     = offset_calc(q_val_r, q_min_r, q_w_r);
   assign dump_last_s = (dump_i == i_nb_r - 8'd1) && (dump_q == q_nb_r - 8'd1);
   assign rd_addr     = (state == ST_DUMP) ? {dump_i, dump_q} : {i_bin_coord, q_bin_coord};

   // State register.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR:  state_nxt = (clr_addr == 16'hFFFF) ? ST_IDLE : ST_CLEAR;
         ST_IDLE:   state_nxt = data_in ? ST_OFFSET : ST_IDLE;
         ST_OFFSET: state_nxt = ST_DIV;
         ST_DIV:    state_nxt = (div_cnt == 3'd7) ? ST_FOUND : ST_DIV;
         ST_FOUND:  state_nxt = ST_READ;
         ST_READ:   state_nxt = ST_WAIT;
         ST_WAIT:   state_nxt = ST_WRITE;
         ST_WRITE:  state_nxt = ST_DONE;
         ST_DONE: begin
            if (!stream_r && (num_pts_r != 16'd0) && (pt_cnt == num_pts_r)) begin
               state_nxt = ST_DUMP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DUMP:   state_nxt = (dump_ph && dump_last_s) ? ST_IDLE : ST_DUMP;
         default:   state_nxt = ST_CLEAR;
      endcase
   end

   // Datapath: capture, divider, bin lookup, outputs and point counter.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         i_val_r <= 32'sd0;  q_val_r <= 32'sd0;
         i_min_r <= 16'sd0;  q_min_r <= 16'sd0;
         i_w_r   <= 16'd1;   q_w_r   <= 16'd1;
         i_nb_r  <= 8'd1;    q_nb_r  <= 8'd1;
         num_pts_r <= 16'd0; stream_r <= 1'b0;
         i_rem_r <= 25'd0;   q_rem_r <= 25'd0;
         i_dvs_r <= 24'd0;   q_dvs_r <= 24'd0;
         i_quo_r <= 8'd0;    q_quo_r <= 8'd0;
         i_sat_r <= 1'b0;    q_sat_r <= 1'b0;
         div_cnt <= 3'd0;    clr_addr <= 16'd0;
         pt_cnt  <= 16'd0;
         dump_i  <= 8'd0;    dump_q <= 8'd0;  dump_ph <= 1'b0;
         i_q_found <= 1'b0;  bin_found <= 1'b0;
         i_bin_coord <= 8'd0; q_bin_coord <= 8'd0;
         bin_val <= 16'd0;
      end else begin
         i_q_found <= 1'b0;
         bin_found <= 1'b0;
         case (state)
            ST_CLEAR: clr_addr <= clr_addr + 16'd1;
            ST_IDLE: begin
               if (data_in) begin
                  i_val_r   <= i_val;
                  q_val_r   <= q_val;
                  i_min_r   <= i_min;
                  q_min_r   <= q_min;
                  i_w_r     <= (i_bin_width == 16'd0) ? 16'd1 : i_bin_width;
                  q_w_r     <= (q_bin_width == 16'd0) ? 16'd1 : q_bin_width;
                  i_nb_r    <= (i_bin_num == 8'd0) ? 8'd1 : i_bin_num;
                  q_nb_r    <= (q_bin_num == 8'd0) ? 8'd1 : q_bin_num;
                  num_pts_r <= num_data_pts;
                  stream_r  <= stream_mode;
               end
            end
            ST_OFFSET: begin
               {i_sat_r, i_rem_r} <= i_off_s;
               {q_sat_r, q_rem_r} <= q_off_s;
               i_dvs_r <= {1'b0, i_w_r, 7'd0};
               q_dvs_r <= {1'b0, q_w_r, 7'd0};
               i_quo_r <= 8'd0;
               q_quo_r <= 8'd0;
               div_cnt <= 3'd0;
            end
            ST_DIV: begin
               // Restoring division against the divisor pre-shifted by 7, one quotient bit per cycle.
               if (i_rem_r >= {1'b0, i_dvs_r}) begin
                  i_rem_r <= i_rem_r - {1'b0, i_dvs_r};
                  i_quo_r <= {i_quo_r[6:0], 1'b1};
               end else begin
                  i_quo_r <= {i_quo_r[6:0], 1'b0};
               end
               if (q_rem_r >= {1'b0, q_dvs_r}) begin
                  q_rem_r <= q_rem_r - {1'b0, q_dvs_r};
                  q_quo_r <= {q_quo_r[6:0], 1'b1};
               end else begin
                  q_quo_r <= {q_quo_r[6:0], 1'b0};
               end
               i_dvs_r <= i_dvs_r >> 1;
               q_dvs_r <= q_dvs_r >> 1;
               div_cnt <= div_cnt + 3'd1;
            end
            ST_FOUND: begin
               i_q_found   <= 1'b1;
               i_bin_coord <= clamp_bin(i_sat_r, i_quo_r, i_nb_r);
               q_bin_coord <= clamp_bin(q_sat_r, q_quo_r, q_nb_r);
            end
            ST_WRITE: begin
               pt_cnt <= pt_cnt + 16'd1;
               if (stream_r) begin
                  bin_found <= 1'b1;
                  bin_val   <= bin_inc(rd_data);
               end
            end
            ST_DONE: begin
               dump_i  <= 8'd0;
               dump_q  <= 8'd0;
               dump_ph <= 1'b0;
            end
            ST_DUMP: begin
               dump_ph <= ~dump_ph;
               if (dump_ph) begin
                  bin_found   <= 1'b1;
                  bin_val     <= rd_data;
                  i_bin_coord <= dump_i;
                  q_bin_coord <= dump_q;
                  if (dump_last_s) begin
                     pt_cnt <= 16'd0;
                  end else if (dump_q == q_nb_r - 8'd1) begin
                     dump_i <= dump_i + 8'd1;
                     dump_q <= 8'd0;
                  end else begin
                     dump_q <= dump_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // RAM write port selection: clear sweep, increment, or dump clear.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_addr;
      mem_wdata = 16'd0;
      case (state)
         ST_CLEAR: mem_we = 1'b1;
         ST_WRITE: begin
            mem_we    = 1'b1;
            mem_waddr = {i_bin_coord, q_bin_coord};
            mem_wdata = bin_inc(rd_data);
         end
         ST_DUMP: begin
            if (dump_ph) begin
               mem_we    = 1'b1;
               mem_waddr = {dump_i, dump_q};
            end else begin
               mem_we    = 1'b0;
            end
         end
         default: mem_we = 1'b0;
      endcase
   end

   // Bin RAM: synchronous write and registered read.
   always_ff @(posedge clk100) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_hist2d_core.sv
// Scoreboard bench for hist2d_core: a histogram model predicts every i_q_found / bin_found pulse.
module tb_hist2d_core;

   logic               clk100 = 1'b0;
   logic               reset = 1'b1;
   logic               data_in = 1'b0;
   logic signed [31:0] i_val = 32'sd0, q_val = 32'sd0;
   logic [7:0]         i_bin_num = 8'd0, q_bin_num = 8'd0;
   logic [15:0]        i_bin_width = 16'd0, q_bin_width = 16'd0;
   logic signed [15:0] i_min = 16'sd0, q_min = 16'sd0;
   logic [15:0]        num_data_pts = 16'd0;
   logic               stream_mode = 1'b0;
   logic               i_q_found, bin_found;
   logic [7:0]         i_bin_coord, q_bin_coord;
   logic [15:0]        bin_val;

   typedef struct {int i; int q; int val; longint at;} exp_t;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   int     hist [256][256];
   int     pts = 0;
   exp_t   iq_q[$];
   exp_t   bf_q[$];

   hist2d_core dut (
      .clk100(clk100), .reset(reset), .data_in(data_in),
      .i_val(i_val), .q_val(q_val),
      .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
      .i_bin_width(i_bin_width), .q_bin_width(q_bin_width),
      .i_min(i_min), .q_min(q_min),
      .num_data_pts(num_data_pts), .stream_mode(stream_mode),
      .i_q_found(i_q_found), .bin_found(bin_found),
      .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
      .bin_val(bin_val)
   );

   always #5 clk100 = ~clk100;
   always @(posedge clk100) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bin of one axis: floor((val - min) / width), negatives to 0, clamped to the grid.
   function automatic int map_bin(input longint v, input longint mn, input longint w, input longint nb);
      longint off, q;
      if (w == 0) w = 1;
      if (nb == 0) nb = 1;
      off = v - mn;
      if (off < 0) q = 0;
      else q = off / w;
      if (q > 255) q = 255;
      if (q > nb - 1) q = nb - 1;
      return int'(q);
   endfunction

   function automatic int count_inc(input int c);
`ifdef HIST2D_SATURATE_EN
      return (c == 65535) ? 65535 : c + 1;
`else
      return (c + 1) % 65536;
`endif
   endfunction

   // Monitor: every output pulse must match the head of its expectation queue.
   always @(negedge clk100) begin
      exp_t e;
      if (!reset) begin
         if (i_q_found) begin
            if (iq_q.size() == 0) chk("iq_unexpected", 1, 0);
            else begin
               e = iq_q.pop_front();
               chk("iq_i_coord", i_bin_coord, e.i);
               chk("iq_q_coord", q_bin_coord, e.q);
               chk("iq_cycle", cyc, e.at);
            end
         end
         if (bin_found) begin
            if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
            else begin
               e = bf_q.pop_front();
               chk("bf_i_coord", i_bin_coord, e.i);
               chk("bf_q_coord", q_bin_coord, e.q);
               chk("bf_val", bin_val, e.val);
               if (e.at >= 0) chk("bf_cycle", cyc, e.at);
            end
         end
      end
   end

   task automatic set_cfg(input int nbi, input int nbq, input int wi, input int wq,
                          input int mi, input int mq, input int num, input bit strm);
      @(negedge clk100);
      i_bin_num = 8'(nbi);     q_bin_num = 8'(nbq);
      i_bin_width = 16'(wi);   q_bin_width = 16'(wq);
      i_min = 16'(mi);         q_min = 16'(mq);
      num_data_pts = 16'(num); stream_mode = strm;
   endtask

   // One sample: push predictions, optionally poke data_in mid-divide, wait out the block.
   task automatic strobe(input int iv, input int qv, input int gap, input bit poke, input bit wait_dump);
      int ib, qb, nbi, nbq, rest;
      longint e0;
      @(negedge clk100);
      i_val = iv; q_val = qv; data_in = 1'b1;
      e0 = cyc + 1;
      ib = map_bin(longint'(iv), longint'(i_min), longint'(i_bin_width), longint'(i_bin_num));
      qb = map_bin(longint'(qv), longint'(q_min), longint'(q_bin_width), longint'(q_bin_num));
      iq_q.push_back('{ib, qb, 0, e0 + 10});
      hist[ib][qb] = count_inc(hist[ib][qb]);
      pts = (pts + 1) % 65536;
      if (stream_mode) bf_q.push_back('{ib, qb, hist[ib][qb], e0 + 13});
      rest = gap;
      @(negedge clk100);
      data_in = 1'b0;
      if (poke) begin
         repeat (3) @(negedge clk100);
         data_in = 1'b1;
         @(negedge clk100);
         data_in = 1'b0;
         rest = rest - 4;
      end
      if (!stream_mode && num_data_pts != 16'd0 && pts == int'(num_data_pts)) begin
         nbi = (i_bin_num == 8'd0) ? 1 : int'(i_bin_num);
         nbq = (q_bin_num == 8'd0) ? 1 : int'(q_bin_num);
         for (int a = 0; a < nbi; a++)
            for (int b = 0; b < nbq; b++) begin
               bf_q.push_back('{a, b, hist[a][b], -1});
               hist[a][b] = 0;
            end
         pts = 0;
         if (wait_dump) rest = rest + 2 * nbi * nbq + 4;
      end
      repeat (rest - 1) @(negedge clk100);
   endtask

   initial begin
      int tv[5];
      tv = '{-3, -2, -1, 0, 1};
      #2;
      chk("rst_i_q_found", i_q_found, 0);
      chk("rst_bin_found", bin_found, 0);
      chk("rst_i_coord", i_bin_coord, 0);
      chk("rst_q_coord", q_bin_coord, 0);
      chk("rst_bin_val", bin_val, 0);
      repeat (3) @(negedge clk100);
      reset = 1'b0;
      repeat (65536 + 20) @(negedge clk100);

      // Dump mode, basic 10x10 grid, with a strobe poked during the divide.
      set_cfg(10, 10, 1, 1, 0, 0, 5, 1'b0);
      for (int k = 0; k < 5; k++) strobe(tv[k], tv[k], 32, (k == 0), 1'b1);

      // Restart: a fresh histogram after the dump.
      for (int k = 0; k < 5; k++)
         strobe(int'($urandom_range(0, 14)) - 3, int'($urandom_range(0, 14)) - 3, 16, 1'b0, 1'b1);

      // Upper clamp and stream mode.
      set_cfg(10, 10, 1, 1, 0, 0, 0, 1'b1);
      strobe(1000, 9, 16, 1'b0, 1'b1);
      set_cfg(8, 8, 4, 4, -16, -16, 0, 1'b1);
      strobe(0, 5, 16, 1'b0, 1'b1);
      strobe(0, 5, 15, 1'b0, 1'b1);

      // Random stream configurations and samples, including zero-sized settings and extremes.
      for (int k = 0; k < 150; k++) begin
         set_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 (k % 7 == 0) ? 0 : int'($urandom_range(1, 300)), int'($urandom_range(0, 40)),
                 int'($urandom), int'($urandom), 0, 1'b1);
         if (k % 3 == 0) strobe(int'($urandom), int'($urandom), 16, 1'b0, 1'b1);
         else strobe(int'(i_min) + int'($urandom_range(0, 2000)) - 100,
                     int'(q_min) + int'($urandom_range(0, 2000)) - 100, 16, 1'b0, 1'b1);
      end

      // Random dumps on small grids; the counter carries the stream-mode residue.
      for (int r = 0; r < 2; r++) begin
         set_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 2, 3, -4, -4,
                 (pts + 6) % 65536, 1'b0);
         for (int k = 0; k < 6; k++)
            strobe(int'($urandom_range(0, 16)) - 6, int'($urandom_range(0, 20)) - 6, 16, 1'b0, 1'b1);
      end

      repeat (20) @(negedge clk100);
      chk("iq_left_over", iq_q.size(), 0);
      chk("bf_left_over", bf_q.size(), 0);

      // Reset in the middle of a dump: outputs drop at once, CLEAR ignores strobes.
      set_cfg(16, 16, 1, 1, 0, 0, (pts + 1) % 65536, 1'b0);
      strobe(3, 4, 16, 1'b0, 1'b0);
      repeat (40) @(negedge clk100);
      #2 reset = 1'b1;
      #1;
      chk("abort_i_q_found", i_q_found, 0);
      chk("abort_bin_found", bin_found, 0);
      chk("abort_i_coord", i_bin_coord, 0);
      chk("abort_q_coord", q_bin_coord, 0);
      chk("abort_bin_val", bin_val, 0);
      iq_q.delete();
      bf_q.delete();
      repeat (3) @(negedge clk100);
      reset = 1'b0;
      data_in = 1'b1;
      repeat (60) @(negedge clk100);
      data_in = 1'b0;
      repeat (30) @(negedge clk100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
